// File: rtl/gg_my_ip_pkg.sv
// Shared types and constants for the gg_my_IP built-in self test.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: operand/result widths, BIST FSM state enum, expected-value
// pipeline record, LFSR tap mask, default seed and LFSR helper functions.
package gg_my_ip_pkg;

    localparam int A_W    = 8;
    localparam int SUM_W  = 9;
    localparam int PROD_W = 16;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 shifting right: feedback is the
    // XOR of register bits 0, 2, 3 and 5, inserted at bit 15.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // One entry of the expected-result delay line.
    typedef struct packed {
        logic              vld;
        logic [SUM_W-1:0]  sum;
        logic [PROD_W-1:0] prod;
    } exp_t;

    // Operands travelling alongside the expected results (mismatch capture).
    typedef struct packed {
        logic [A_W-1:0] a;
        logic [A_W-1:0] b;
    } opd_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

    // An all-zero state would lock the LFSR, so zero seeds become 1.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/gg_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and single-step advance.
// Latency: q updates on the clock edge after load/adv.
// Backpressure: none; holds its state whenever adv and load are low.
//
// Ports: clk, reset (sync, active high, loads seed), load (reload seed),
//        seed[15:0], adv (step once), q[15:0] current state.
// load together with adv loads the seed and steps past it in one edge, so
// the caller can consume the seed itself as the first value that cycle.
module gg_lfsr16
    import gg_my_ip_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] q
);

    logic [15:0] seed_eff;

    assign seed_eff = lfsr_seed_fix(seed);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed_eff;
        end else if (load) begin
            q <= adv ? lfsr_step(seed_eff) : seed_eff;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/gg_my_ip_bist.sv
// Self-test for gg_my_IP: issues LFSR operand pairs, checks sum/prod, counts errors.
// Latency: first vector the cycle after start; done N_VECTORS+LATENCY+1 cycles after start.
// Backpressure: none; one vector per clock, start ignored while busy.
//
// Ports: clk, reset (sync, active high), start (pulse), a_o/b_o operands to
//        the IP, sum_i/prod_i IP results, busy (RUN/DRAIN), done (DONE),
//        pass (valid with done), vec_count (compares, wraps),
//        err_count (mismatches, saturating).
// Build option GG_BIST_ERR_CAPTURE_EN adds fail_a/fail_b/fail_sum/fail_prod,
// which hold the operands and IP results of the first mismatch of a run.
module gg_my_ip_bist
    import gg_my_ip_pkg::*;
#(
    parameter int          N_VECTORS = 19500,
    parameter int          LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          COUNT_W   = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [A_W-1:0]     a_o,
    output logic [A_W-1:0]     b_o,
    input  logic [SUM_W-1:0]   sum_i,
    input  logic [PROD_W-1:0]  prod_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] vec_count,
    output logic [COUNT_W-1:0] err_count
`ifdef GG_BIST_ERR_CAPTURE_EN
    ,
    output logic [A_W-1:0]     fail_a,
    output logic [A_W-1:0]     fail_b,
    output logic [SUM_W-1:0]   fail_sum,
    output logic [PROD_W-1:0]  fail_prod
`endif
);

    localparam int ISS_W = $clog2(N_VECTORS + 1);
    localparam int DRN_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    bist_state_t      state_q;
    bist_state_t      state_d;
    logic             start_acc;
    logic             issue;
    logic             finish;
    logic [ISS_W-1:0] iss_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic [15:0]      lfsr_q;
    logic [15:0]      seed_eff;
    logic             a_vld;
    exp_t             exp_in;
    exp_t             chk;
    exp_t             dly_q [LATENCY];
    logic             mism;

    assign seed_eff = lfsr_seed_fix(LFSR_SEED);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN lasts LATENCY+1 cycles: LATENCY for the IP pipeline to deliver
    // the last result, plus one for that compare to land in the counters
    // before pass is sampled.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                    issue     = 1'b1;
                end
            end
            RUN: begin
                if (iss_cnt == ISS_W'(N_VECTORS)) begin
                    state_d = DRAIN;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (drn_cnt == DRN_W'(LATENCY)) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            drn_cnt <= '0;
        end else if (state_q == DRAIN && !finish) begin
            drn_cnt <= drn_cnt + DRN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    gg_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .seed  (LFSR_SEED),
        .adv   (issue),
        .q     (lfsr_q)
    );

    // The start edge itself issues the seed as vector 0 (the LFSR steps past
    // it in the same edge), so operands follow start by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_o     <= '0;
            b_o     <= '0;
            a_vld   <= 1'b0;
            iss_cnt <= '0;
        end else begin
            a_vld <= issue;
            if (issue) begin
                a_o     <= start_acc ? seed_eff[15:8] : lfsr_q[15:8];
                b_o     <= start_acc ? seed_eff[7:0]  : lfsr_q[7:0];
                iss_cnt <= start_acc ? ISS_W'(1) : iss_cnt + ISS_W'(1);
            end else begin
                a_o <= '0;
                b_o <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Expected values, aligned to the IP latency
    // ------------------------------------------------------------------
    always_comb begin
        exp_in      = '0;
        exp_in.vld  = a_vld;
        exp_in.sum  = SUM_W'(a_o) + SUM_W'(b_o);
        exp_in.prod = PROD_W'(a_o) * PROD_W'(b_o);
    end

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            for (int i = 0; i < LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= exp_in;
            for (int i = 1; i < LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign chk  = dly_q[LATENCY-1];
    assign mism = chk.vld && ((sum_i != chk.sum) || (prod_i != chk.prod));

    // ------------------------------------------------------------------
    // Counters and verdict
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            vec_count <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (chk.vld) begin
                vec_count <= vec_count + COUNT_W'(1);
            end
            if (mism && (err_count != '1)) begin
                err_count <= err_count + COUNT_W'(1);
            end
            // Last compare landed the cycle before, so err_count is final.
            if (finish) begin
                pass <= (err_count == '0);
            end
        end
    end

`ifdef GG_BIST_ERR_CAPTURE_EN
    // ------------------------------------------------------------------
    // First-mismatch capture
    // ------------------------------------------------------------------
    opd_t opd_q [LATENCY];

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            for (int i = 0; i < LATENCY; i++) begin
                opd_q[i] <= '0;
            end
        end else begin
            opd_q[0] <= '{a: a_o, b: b_o};
            for (int i = 1; i < LATENCY; i++) begin
                opd_q[i] <= opd_q[i-1];
            end
        end
    end

    // err_count is cleared on start, so zero means no mismatch yet this run.
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sum  <= '0;
            fail_prod <= '0;
        end else if (mism && (err_count == '0)) begin
            fail_a    <= opd_q[LATENCY-1].a;
            fail_b    <= opd_q[LATENCY-1].b;
            fail_sum  <= sum_i;
            fail_prod <= prod_i;
        end
    end
`endif

endmodule
